// File: rtl/l1c_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// l1c_mem_arbiter_pkg
// Shared cache constants for the L1 memory-port arbiter: access-size encodings,
// refill geometry, the arbiter state enum and the round-robin pick helper.
// No ports (package).
// -----------------------------------------------------------------------------
package l1c_mem_arbiter_pkg;

   // Refill geometry: 128-bit line fetched as four 32-bit beats
   localparam int BEATS = 4;
   localparam int CNT_W = 2;

   // Access-size encodings carried on D_type / M_type
   localparam int CACHE_TYPE_BITS = 2;
   localparam logic [CACHE_TYPE_BITS-1:0] CACHE_BYTE = 2'd0;
   localparam logic [CACHE_TYPE_BITS-1:0] CACHE_HALF = 2'd1;
   localparam logic [CACHE_TYPE_BITS-1:0] CACHE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GNT_I = 2'd1,
      ARB_GNT_D = 2'd2
   } arb_state_e;

   // Returns 1 when the data cache should be granted. On a tie the cache that
   // did not own the port last time wins (last: 0 = I, 1 = D).
   function automatic logic rr_pick_d(input logic i_req, input logic d_req,
                                      input logic last);
      logic pick;
      if (i_req && d_req) begin
         pick = ~last;
      end else if (d_req) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction

endpackage

// File: rtl/l1c_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// l1c_mem_arbiter_if
// Bundles the instruction-cache, data-cache and memory-port signals seen by
// the arbiter.
//   master : arbiter view (drives waits, read data and the memory requests)
//   slave  : environment view (caches and memory side)
// Signals:
//   I_rreq/I_addr -> I_wait/I_out                 instruction cache refill
//   D_rreq/D_wreq/D_addr/D_in/D_type -> D_wait/D_out   data cache
//   M_rreq/M_wreq/M_addr/M_in/M_type <- M_out/M_wait   memory port
// -----------------------------------------------------------------------------
interface l1c_mem_arbiter_if;
   import l1c_mem_arbiter_pkg::*;

   logic                       I_rreq;
   logic [31:0]                I_addr;
   logic                       I_wait;
   logic [31:0]                I_out;

   logic                       D_rreq;
   logic                       D_wreq;
   logic [31:0]                D_addr;
   logic [31:0]                D_in;
   logic [CACHE_TYPE_BITS-1:0] D_type;
   logic                       D_wait;
   logic [31:0]                D_out;

   logic                       M_rreq;
   logic                       M_wreq;
   logic [31:0]                M_addr;
   logic [31:0]                M_in;
   logic [CACHE_TYPE_BITS-1:0] M_type;
   logic [31:0]                M_out;
   logic                       M_wait;

   modport master (
      input  I_rreq, I_addr, D_rreq, D_wreq, D_addr, D_in, D_type, M_out, M_wait,
      output I_wait, I_out, D_wait, D_out, M_rreq, M_wreq, M_addr, M_in, M_type
   );

   modport slave (
      output I_rreq, I_addr, D_rreq, D_wreq, D_addr, D_in, D_type, M_out, M_wait,
      input  I_wait, I_out, D_wait, D_out, M_rreq, M_wreq, M_addr, M_in, M_type
   );

endinterface

// File: rtl/l1c_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1c_mem_arbiter
// Shares the single memory port between the L1 instruction cache (4-beat line
// refills) and the L1 data cache (4-beat refills or single-word writes). One
// requester owns the port for a whole transaction; ties are broken
// round-robin. The memory-side signals and the waits are combinational from
// the grant state and the granted cache's inputs; read data is passed straight
// through to both caches.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : l1c_mem_arbiter_if.master (cache and memory-port signals)
// -----------------------------------------------------------------------------
module l1c_mem_arbiter
   import l1c_mem_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   l1c_mem_arbiter_if.master     bus
);

   arb_state_e        state_q, state_d;
   logic              last_q,  last_d;   // 0 = I owned the port last, 1 = D
   logic [CNT_W-1:0]  cnt_q,   cnt_d;    // beats accepted in the current refill
   logic              dwr_q,   dwr_d;    // data-cache transaction kind, 1 = write

   logic              i_req_s;
   logic              d_req_s;
   logic              last_beat_s;

   assign i_req_s     = bus.I_rreq;
   assign d_req_s     = bus.D_rreq | bus.D_wreq;
   assign last_beat_s = (cnt_q == CNT_W'(BEATS - 1));

   // Read data goes to both caches; only the granted one samples it
   assign bus.I_out = bus.M_out;
   assign bus.D_out = bus.M_out;

   // Grant state, round-robin history, beat counter and latched D kind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         dwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         dwr_q   <= dwr_d;
      end
   end

   // Next-state selection and memory-port / wait muxing
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      dwr_d      = dwr_q;
      bus.M_rreq = 1'b0;
      bus.M_wreq = 1'b0;
      bus.M_addr = 32'h0000_0000;
      bus.M_in   = 32'h0000_0000;
      bus.M_type = CACHE_WORD;
      bus.I_wait = 1'b1;
      bus.D_wait = 1'b1;

      case (state_q)
         ARB_IDLE: begin
            if (i_req_s || d_req_s) begin
               cnt_d = '0;
               if (rr_pick_d(i_req_s, d_req_s, last_q)) begin
                  state_d = ARB_GNT_D;
                  last_d  = 1'b1;
                  // A cache raising both requests is treated as a write
                  dwr_d   = bus.D_wreq;
               end else begin
                  state_d = ARB_GNT_I;
                  last_d  = 1'b0;
               end
            end else begin
               state_d = ARB_IDLE;
            end
         end

         ARB_GNT_I: begin
            bus.M_rreq = bus.I_rreq;
            bus.M_addr = bus.I_addr;
            bus.I_wait = bus.M_wait;
            if (!bus.I_rreq) begin
               // Requester gave up: abandon the partial refill
               state_d = ARB_IDLE;
               cnt_d   = '0;
            end else if (!bus.M_wait) begin
               if (last_beat_s) begin
                  state_d = ARB_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ARB_GNT_I;
            end
         end

         ARB_GNT_D: begin
            bus.M_addr = bus.D_addr;
            bus.D_wait = bus.M_wait;
            if (dwr_q) begin
               bus.M_wreq = bus.D_wreq;
               bus.M_in   = bus.D_in;
               bus.M_type = bus.D_type;
               // Dropped request or single accepted beat both end the write
               if (!bus.D_wreq || !bus.M_wait) begin
                  state_d = ARB_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = ARB_GNT_D;
               end
            end else begin
               bus.M_rreq = bus.D_rreq;
               if (!bus.D_rreq) begin
                  state_d = ARB_IDLE;
                  cnt_d   = '0;
               end else if (!bus.M_wait) begin
                  if (last_beat_s) begin
                     state_d = ARB_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d = ARB_GNT_D;
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l1c_mem_arbiter
// Directed self-checking bench for l1c_mem_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_l1c_mem_arbiter;
   import l1c_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   // 10-unit clock
   always #5 clk = ~clk;

   l1c_mem_arbiter_if bus ();

   l1c_mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      bus.I_rreq = 1'b0;
      bus.I_addr = 32'h0000_0000;
      bus.D_rreq = 1'b0;
      bus.D_wreq = 1'b0;
      bus.D_addr = 32'h0000_0000;
      bus.D_in   = 32'h0000_0000;
      bus.D_type = CACHE_WORD;
      bus.M_wait = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      clear_inputs();
      bus.M_out = 32'h1234_5678;
      mid();
      checks++; if (bus.M_rreq !== 1'b0) begin errors++; $display("FAIL reset_m_rreq got=%0b exp=0", bus.M_rreq); end
      checks++; if (bus.M_wreq !== 1'b0) begin errors++; $display("FAIL reset_m_wreq got=%0b exp=0", bus.M_wreq); end
      checks++; if (bus.M_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got=%0h exp=0", bus.M_addr); end
      checks++; if (bus.M_in !== 32'h0) begin errors++; $display("FAIL reset_m_in got=%0h exp=0", bus.M_in); end
      checks++; if (bus.M_type !== CACHE_WORD) begin errors++; $display("FAIL reset_m_type got=%0d exp=%0d", bus.M_type, CACHE_WORD); end
      checks++; if (bus.I_wait !== 1'b1 || bus.D_wait !== 1'b1) begin errors++; $display("FAIL reset_waits got=%0b%0b exp=11", bus.I_wait, bus.D_wait); end
      checks++; if (bus.I_out !== 32'h1234_5678 || bus.D_out !== 32'h1234_5678) begin errors++; $display("FAIL reset_rdata got=%0h/%0h exp=12345678", bus.I_out, bus.D_out); end
      checks++; if (dut.last_q !== 1'b1 || dut.cnt_q !== 2'd0) begin errors++; $display("FAIL reset_regs last=%0b cnt=%0d exp last=1 cnt=0", dut.last_q, dut.cnt_q); end
      // Requests during reset must not be granted
      bus.I_rreq = 1'b1;
      bus.D_wreq = 1'b1;
      tick();
      mid();
      checks++; if (bus.M_rreq !== 1'b0 || bus.M_wreq !== 1'b0) begin errors++; $display("FAIL reset_hold_req got=%0b%0b exp=00", bus.M_rreq, bus.M_wreq); end
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_i_refill;
      bus.I_rreq = 1'b1;
      bus.I_addr = 32'h0000_1230;
      bus.M_wait = 1'b0;
      mid();
      checks++; if (bus.M_rreq !== 1'b0 || bus.I_wait !== 1'b1) begin errors++; $display("FAIL irefill_idle rreq=%0b iwait=%0b exp 0/1", bus.M_rreq, bus.I_wait); end
      for (int b = 0; b < 4; b++) begin
         tick();
         mid();
         checks++; if (bus.M_rreq !== 1'b1 || bus.M_addr !== 32'h0000_1230) begin errors++; $display("FAIL irefill_beat%0d rreq=%0b addr=%0h exp 1/1230", b, bus.M_rreq, bus.M_addr); end
         checks++; if (bus.I_wait !== 1'b0 || bus.D_wait !== 1'b1) begin errors++; $display("FAIL irefill_wait%0d got=%0b%0b exp=01", b, bus.I_wait, bus.D_wait); end
         checks++; if (dut.cnt_q !== b[1:0]) begin errors++; $display("FAIL irefill_cnt%0d got=%0d exp=%0d", b, dut.cnt_q, b); end
      end
      tick();
      bus.I_rreq = 1'b0;
      mid();
      checks++; if (bus.M_rreq !== 1'b0 || bus.I_wait !== 1'b1 || dut.state_q !== ARB_IDLE) begin errors++; $display("FAIL irefill_end rreq=%0b iwait=%0b state=%0d exp 0/1/0", bus.M_rreq, bus.I_wait, dut.state_q); end
      tick();
   endtask

   task automatic test_tie_after_reset;
      do_reset();
      bus.I_rreq = 1'b1;
      bus.D_rreq = 1'b1;
      bus.I_addr = 32'h0000_0100;
      bus.D_addr = 32'h0000_0200;
      for (int b = 0; b < 4; b++) begin
         tick();
         mid();
         checks++; if (bus.M_addr !== 32'h0000_0100 || bus.I_wait !== 1'b0 || bus.D_wait !== 1'b1) begin errors++; $display("FAIL tie_i_beat%0d addr=%0h waits=%0b%0b exp 100/01", b, bus.M_addr, bus.I_wait, bus.D_wait); end
      end
      tick();
      bus.I_rreq = 1'b0;
      mid();
      checks++; if (bus.M_rreq !== 1'b0 || bus.D_wait !== 1'b1 || dut.last_q !== 1'b0) begin errors++; $display("FAIL tie_gap rreq=%0b dwait=%0b last=%0b exp 0/1/0", bus.M_rreq, bus.D_wait, dut.last_q); end
      for (int b = 0; b < 4; b++) begin
         tick();
         mid();
         checks++; if (bus.M_rreq !== 1'b1 || bus.M_addr !== 32'h0000_0200 || bus.D_wait !== 1'b0 || bus.I_wait !== 1'b1) begin errors++; $display("FAIL tie_d_beat%0d rreq=%0b addr=%0h waits=%0b%0b exp 1/200/10", b, bus.M_rreq, bus.M_addr, bus.I_wait, bus.D_wait); end
      end
      tick();
      bus.D_rreq = 1'b0;
      mid();
      checks++; if (bus.M_rreq !== 1'b0 || dut.last_q !== 1'b1) begin errors++; $display("FAIL tie_end rreq=%0b last=%0b exp 0/1", bus.M_rreq, dut.last_q); end
      tick();
   endtask

   task automatic test_d_write;
      bus.D_wreq = 1'b1;
      bus.D_addr = 32'h0001_0004;
      bus.D_in   = 32'hDEAD_BEEF;
      bus.D_type = CACHE_BYTE;
      bus.M_wait = 1'b1;
      mid();
      checks++; if (bus.M_wreq !== 1'b0) begin errors++; $display("FAIL dwrite_idle got=%0b exp=0", bus.M_wreq); end
      for (int k = 0; k < 3; k++) begin
         tick();
         // A late read request must not turn the latched write into a read
         if (k >= 1) bus.D_rreq = 1'b1;
         mid();
         checks++; if (bus.M_wreq !== 1'b1 || bus.M_rreq !== 1'b0 || bus.D_wait !== 1'b1) begin errors++; $display("FAIL dwrite_hold%0d wreq=%0b rreq=%0b dwait=%0b exp 1/0/1", k, bus.M_wreq, bus.M_rreq, bus.D_wait); end
         checks++; if (bus.M_addr !== 32'h0001_0004 || bus.M_in !== 32'hDEAD_BEEF || bus.M_type !== CACHE_BYTE) begin errors++; $display("FAIL dwrite_bus%0d addr=%0h in=%0h type=%0d exp 10004/deadbeef/0", k, bus.M_addr, bus.M_in, bus.M_type); end
      end
      tick();
      bus.M_wait = 1'b0;
      mid();
      checks++; if (bus.M_wreq !== 1'b1 || bus.D_wait !== 1'b0) begin errors++; $display("FAIL dwrite_accept wreq=%0b dwait=%0b exp 1/0", bus.M_wreq, bus.D_wait); end
      tick();
      clear_inputs();
      mid();
      checks++; if (bus.M_wreq !== 1'b0 || bus.M_in !== 32'h0 || bus.M_type !== CACHE_WORD || bus.D_wait !== 1'b1) begin errors++; $display("FAIL dwrite_end wreq=%0b in=%0h type=%0d dwait=%0b exp 0/0/2/1", bus.M_wreq, bus.M_in, bus.M_type, bus.D_wait); end
      tick();
   endtask

   task automatic test_wait_toggle;
      logic wp [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0] beats = 2'd0;
      bus.I_rreq = 1'b1;
      bus.I_addr = 32'h0000_2000;
      tick();
      for (int c = 0; c < 7; c++) begin
         bus.M_wait = wp[c];
         mid();
         checks++; if (bus.M_rreq !== 1'b1 || bus.I_wait !== wp[c]) begin errors++; $display("FAIL wtog_cyc%0d rreq=%0b iwait=%0b exp 1/%0b", c, bus.M_rreq, bus.I_wait, wp[c]); end
         checks++; if (dut.cnt_q !== beats) begin errors++; $display("FAIL wtog_cnt%0d got=%0d exp=%0d", c, dut.cnt_q, beats); end
         tick();
         if (!wp[c]) beats = beats + 2'd1;
      end
      bus.I_rreq = 1'b0;
      bus.M_wait = 1'b0;
      mid();
      checks++; if (dut.state_q !== ARB_IDLE || dut.cnt_q !== 2'd0 || bus.M_rreq !== 1'b0) begin errors++; $display("FAIL wtog_end state=%0d cnt=%0d rreq=%0b exp 0/0/0", dut.state_q, dut.cnt_q, bus.M_rreq); end
      tick();
   endtask

   task automatic test_reset_mid;
      bus.D_rreq = 1'b1;
      bus.D_addr = 32'h0000_3000;
      bus.M_wait = 1'b0;
      tick();
      tick();
      tick();
      mid();
      checks++; if (bus.M_rreq !== 1'b1 || dut.cnt_q !== 2'd2) begin errors++; $display("FAIL rstmid_pre rreq=%0b cnt=%0d exp 1/2", bus.M_rreq, dut.cnt_q); end
      rst = 1'b1;
      #1;
      checks++; if (bus.M_rreq !== 1'b0 || bus.M_addr !== 32'h0 || bus.D_wait !== 1'b1 || bus.I_wait !== 1'b1) begin errors++; $display("FAIL rstmid_async rreq=%0b addr=%0h waits=%0b%0b exp 0/0/11", bus.M_rreq, bus.M_addr, bus.I_wait, bus.D_wait); end
      checks++; if (dut.cnt_q !== 2'd0 || dut.last_q !== 1'b1) begin errors++; $display("FAIL rstmid_regs cnt=%0d last=%0b exp 0/1", dut.cnt_q, dut.last_q); end
      clear_inputs();
      tick();
      rst = 1'b0;
      bus.I_rreq = 1'b1;
      bus.I_addr = 32'h0000_4000;
      mid();
      checks++; if (bus.M_rreq !== 1'b0) begin errors++; $display("FAIL rstmid_idle rreq=%0b exp=0", bus.M_rreq); end
      tick();
      mid();
      checks++; if (bus.M_rreq !== 1'b1 || bus.I_wait !== 1'b0 || bus.M_addr !== 32'h0000_4000) begin errors++; $display("FAIL rstmid_regrant rreq=%0b iwait=%0b addr=%0h exp 1/0/4000", bus.M_rreq, bus.I_wait, bus.M_addr); end
      // Dropping the request abandons the refill on the next edge
      bus.I_rreq = 1'b0;
      tick();
      mid();
      checks++; if (dut.state_q !== ARB_IDLE || dut.cnt_q !== 2'd0 || bus.I_wait !== 1'b1) begin errors++; $display("FAIL rstmid_abandon state=%0d cnt=%0d iwait=%0b exp 0/0/1", dut.state_q, dut.cnt_q, bus.I_wait); end
      tick();
   endtask

   task automatic test_back_to_back;
      int exp_g;
      int obs_g;
      logic [31:0] exp_a;
      do_reset();
      bus.I_rreq = 1'b1;
      bus.D_rreq = 1'b1;
      bus.I_addr = 32'h0000_5000;
      bus.D_addr = 32'h0000_6000;
      // Expected: IDLE, I x4, IDLE, D x4, IDLE, I x4, IDLE, D x4
      for (int t = 0; t < 20; t++) begin
         if (t % 5 == 0) begin
            exp_g = 0;
            exp_a = 32'h0;
         end else if ((t / 5) % 2 == 0) begin
            exp_g = 1;
            exp_a = 32'h0000_5000;
         end else begin
            exp_g = 2;
            exp_a = 32'h0000_6000;
         end
         mid();
         obs_g = (!bus.I_wait) ? 1 : ((!bus.D_wait) ? 2 : 0);
         checks++; if (obs_g !== exp_g || bus.M_addr !== exp_a) begin errors++; $display("FAIL b2b_cyc%0d grant=%0d addr=%0h exp %0d/%0h", t, obs_g, bus.M_addr, exp_g, exp_a); end
         tick();
      end
      clear_inputs();
      mid();
      checks++; if (dut.state_q !== ARB_IDLE || dut.last_q !== 1'b1) begin errors++; $display("FAIL b2b_end state=%0d last=%0b exp 0/1", dut.state_q, dut.last_q); end
      tick();
   endtask

   // Test sequence
   initial begin
      rst = 1'b1;
      clear_inputs();
      bus.M_out = 32'h0000_0000;
      test_reset();
      test_i_refill();
      test_tie_after_reset();
      test_d_write();
      test_wait_toggle();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l1c_mem_arbiter.md
# l1c_mem_arbiter

Shares the single CPU-wrapper memory port between the L1 instruction cache (line refills) and the L1 data cache (line refills and single-word writes). It sits between both L1 caches and the CPU wrapper. It grants one requester at a time and holds the grant for a whole transaction. Simultaneous requests are resolved round-robin. The memory port is muxed to the granted cache, and the other cache is stalled.

## Interface
- BEATS, 4, read beats per line refill (128-bit line / 32-bit word)
- CNT_W, 2, beat counter width, clog2(BEATS)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- I_rreq  in  1  instruction cache refill request, held high until its last beat is accepted
- I_addr  in  32  instruction refill line address, bits [3:0] = 0
- I_wait  out  1  wait to instruction cache
- I_out  out  32  read data to instruction cache
- D_rreq  in  1  data cache refill request
- D_wreq  in  1  data cache single-word write request
- D_addr  in  32  data cache address
- D_in  in  32  write data
- D_type  in  CACHE_TYPE_BITS  write size (byte/half/word)
- D_wait  out  1  wait to data cache
- D_out  out  32  read data to data cache
- M_rreq, M_wreq  out  1  each  memory-port requests
- M_addr  out  32  memory-port address
- M_in  out  32  memory-port write data
- M_type  out  CACHE_TYPE_BITS  memory-port size
- M_out  in  32  memory-port read data
- M_wait  in  1  memory-port wait; a beat is accepted in any cycle where a request is high and M_wait is low

## Operation
- State register with three states:
  - IDLE: no grant.
  - GNT_I: instruction cache owns the port.
  - GNT_D: data cache owns the port.
- Register `last` (0 = I, 1 = D) holds the most recent grant; it resets to 1, so I wins the first tie.
- Transitions out of IDLE:
  - Only I requesting → GNT_I.
  - Only D requesting (D_rreq | D_wreq) → GNT_D.
  - Both requesting → the one not equal to `last`.
  - Neither requesting → stay in IDLE.
- Entering a grant loads `last` and clears the beat counter `cnt`.
- When D_rreq and D_wreq are both high, the data cache is faulty. The arbiter treats it as a write and does not check further.
- In GNT_I:
  - M_rreq = I_rreq and M_addr = I_addr.
  - M_wreq = 0, M_in = 0, M_type = CACHE_WORD.
  - I_wait = M_wait and D_wait = 1.
  - Each accepted beat increments `cnt`. The beat accepted with cnt == BEATS-1 returns to IDLE.
- GNT_D, read: same as GNT_I with the D signals.
- GNT_D, write:
  - M_wreq = D_wreq, M_addr = D_addr, M_in = D_in, M_type = D_type.
  - The first accepted beat returns to IDLE.
- The transaction kind is latched when GNT_D is entered. Mid-transaction changes to D_rreq or D_wreq do not change the kind.
- Read data passes straight through: I_out = M_out and D_out = M_out at all times. Only the granted cache samples it.
- A requester that drops its request during its grant returns the arbiter to IDLE on the next edge; the partial transaction is abandoned.
- In IDLE: M_rreq = M_wreq = 0, M_addr = 0, M_in = 0, M_type = CACHE_WORD, I_wait = D_wait = 1.

## Timing
- Grant latency: a request first seen in IDLE at edge n puts the arbiter in the grant state after edge n. M_rreq/M_wreq go high in cycle n+1, combinationally from state and the request.
- Memory-side outputs and waits are combinational from the state plus the granted requester's inputs. There is no added data latency.
- Minimum refill with M_wait = 0 throughout: 1 IDLE cycle + 4 beat cycles. Minimum write: 1 + 1 cycles.
- Back-to-back transactions: after the final beat the arbiter is in IDLE for exactly one cycle before the next grant. Round-robin is evaluated in that cycle.
- Reset values: state IDLE, cnt 0, `last` 1. Outputs take the IDLE values above. A reset asserted mid-transaction aborts it immediately and asynchronously.
- cnt wraps to 0 when leaving the grant; it never exceeds BEATS-1.

## Structure
- Arbiter state enum, CACHE_WORD and CACHE_TYPE_BITS belong in the shared cache package / def.svh alongside the existing cache constants.
- The block is a single module with no sub-module. The round-robin choice is a few lines of combinational logic and is not worth a separate block.

## Test plan
- I-only refill, addr 0x0000_1230, M_wait = 0 → GNT_I in the next cycle, 4 beats with M_addr = 0x0000_1230, back to IDLE, D_wait = 1 throughout.
- Simultaneous I_rreq and D_rreq straight out of reset → I granted first (last = 1). D is granted after I's 4th beat plus one IDLE cycle; last ends at 1.
- D write 0xDEAD_BEEF to 0x0001_0004 with D_type = byte and M_wait = 1 for 3 cycles → M_wreq is held for those cycles, accepted in the 4th, then IDLE. M_in and M_type match D_in and D_type.
- I refill with M_wait toggling 1,0,1,0,0,1,0 → exactly 4 beats counted, and I_wait mirrors M_wait.
- rst asserted after 2 beats of a D refill → all outputs return to IDLE values in the same cycle, and a fresh I request after rst falls is granted normally.
- Persistent I and D requests for 4 transactions → grants alternate I, D, I, D; no requester is starved.
